// File: rtl/shift_issue_stage_if.sv
// Decode-side and writeback-side valid/ready bundles
// for the shift issue stage.
interface shift_issue_stage_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [3:0]    in_amt;
  logic [2:0]    in_op;
  logic [RW-1:0] in_rd;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic          out_z;
  logic          out_err;

  modport master (
    output in_valid, in_data, in_amt,
    output in_op, in_rd,
    input  in_ready,
    input  out_valid, out_data, out_rd,
    input  out_z, out_err,
    output out_ready
  );

  modport slave (
    input  in_valid, in_data, in_amt,
    input  in_op, in_rd,
    output in_ready,
    output out_valid, out_data, out_rd,
    output out_z, out_err,
    input  out_ready
  );
endinterface

// File: rtl/shift_issue_stage.sv
// Two-stage issue/retire wrapper around the external
// 16-bit barrel shifter (SLL/SRA/ROR) with flush.
module shift_issue_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  shift_issue_stage_if.slave io,
  output logic [DW-1:0] sh_in,
  output logic [3:0]    sh_val,
  output logic [2:0]    sh_op,
  input  logic [DW-1:0] sh_out
);
  logic          a_valid_q, a_valid_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic [3:0]    a_amt_q, a_amt_d;
  logic [2:0]    a_op_q, a_op_d;
  logic [RW-1:0] a_rd_q, a_rd_d;

  logic          b_valid_q, b_valid_d;
  logic [DW-1:0] b_data_q, b_data_d;
  logic [RW-1:0] b_rd_q, b_rd_d;
  logic          b_z_q, b_z_d;
  logic          b_err_q, b_err_d;

  logic          b_free;
  logic          a_adv;
  logic          in_fire;
  logic          legal;
  logic [DW-1:0] res;

  assign b_free      = !b_valid_q | io.out_ready;
  assign a_adv       = a_valid_q & b_free;
  assign io.in_ready = (!a_valid_q | b_free) & !flush;
  assign in_fire     = io.in_valid & io.in_ready;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      (a_op_q == 3'b100): legal = 1'b1;
      (a_op_q == 3'b101): legal = 1'b1;
      (a_op_q == 3'b110): legal = 1'b1;
      default:            legal = 1'b0;
    endcase
  end

  // Illegal ops bypass the shifter so the operand is retired intact.
  assign res = legal ? sh_out : a_data_q;

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_amt_d   = a_amt_q;
    a_op_d    = a_op_q;
    a_rd_d    = a_rd_q;
    if (in_fire) begin
      a_valid_d = 1'b1;
      a_data_d  = io.in_data;
      a_amt_d   = io.in_amt;
      a_op_d    = io.in_op;
      a_rd_d    = io.in_rd;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end
    if (flush) a_valid_d = 1'b0;
  end

  always_comb begin
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_rd_d    = b_rd_q;
    b_z_d     = b_z_q;
    b_err_d   = b_err_q;
    if (a_adv) begin
      b_valid_d = 1'b1;
      b_data_d  = res;
      b_rd_d    = a_rd_q;
      b_z_d     = (res == '0);
      b_err_d   = !legal;
    end else if (io.out_ready) begin
      b_valid_d = 1'b0;
    end
    if (flush) b_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_amt_q   <= '0;
      a_op_q    <= '0;
      a_rd_q    <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_rd_q    <= '0;
      b_z_q     <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_amt_q   <= a_amt_d;
      a_op_q    <= a_op_d;
      a_rd_q    <= a_rd_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_rd_q    <= b_rd_d;
      b_z_q     <= b_z_d;
      b_err_q   <= b_err_d;
    end
  end

  assign sh_in  = a_data_q;
  assign sh_val = a_amt_q;
  assign sh_op  = a_op_q;

  assign io.out_valid = b_valid_q;
  assign io.out_data  = b_data_q;
  assign io.out_rd    = b_rd_q;
  assign io.out_z     = b_z_q;
  assign io.out_err   = b_err_q;
endmodule

// File: tb/tb_shift_issue_stage.sv
// Random + directed bench for shift_issue_stage against
// an in-order queue model of the shift unit.
module tb_shift_issue_stage;
  localparam int DW = 16;
  localparam int RW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] sh_in;
  logic [3:0]    sh_val;
  logic [2:0]    sh_op;
  logic [DW-1:0] sh_out;

  shift_issue_stage_if #(.DW(DW), .RW(RW)) io();

  shift_issue_stage #(.DW(DW), .RW(RW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .io     (io),
    .sh_in  (sh_in),
    .sh_val (sh_val),
    .sh_op  (sh_op),
    .sh_out (sh_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  rd;
    logic        z;
    logic        err;
  } res_t;

  res_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic last_acc;
  logic prev_hold = 1'b0;
  res_t prev;

  function automatic logic [15:0] ref_shift(
    logic [15:0] d, logic [3:0] n, logic [2:0] op);
    logic [31:0] w;
    case (op)
      3'b100: return d << n;
      3'b101: return 16'($signed(d) >>> n);
      3'b110: begin
        w = {d, d} >> n;
        return w[15:0];
      end
      default: return d;
    endcase
  endfunction

  function automatic logic is_legal(logic [2:0] op);
    return op inside {3'b100, 3'b101, 3'b110};
  endfunction

  // Stand-in shifter; junk on illegal codes.
  always_comb begin
    sh_out = ~sh_in;
    if (is_legal(sh_op))
      sh_out = ref_shift(sh_in, sh_val, sh_op);
  end

  function automatic res_t mk(
    logic [15:0] d, logic [3:0] n,
    logic [2:0] op, logic [3:0] rd);
    res_t e;
    e.d   = ref_shift(d, n, op);
    e.rd  = rd;
    e.z   = (e.d == 16'h0);
    e.err = !is_legal(op);
    return e;
  endfunction

  task automatic check(string tag,
    logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
        tag, got, exp);
    end
  endtask

  task automatic drive(logic v, logic [15:0] d,
    logic [3:0] n, logic [2:0] op, logic [3:0] rd);
    io.in_valid = v;
    io.in_data  = d;
    io.in_amt   = n;
    io.in_op    = op;
    io.in_rd    = rd;
  endtask

  task automatic tick();
    logic rdy, ov, exp_rdy;
    res_t e;
    #1;
    rdy = io.in_ready;
    ov  = io.out_valid;
    exp_rdy = !flush && (q.size() < 2 || io.out_ready);
    check("in_ready", rdy, exp_rdy);
    if (prev_hold) begin
      check("hold_v", ov, 1);
      check("hold_d", io.out_data, prev.d);
      check("hold_rd", io.out_rd, prev.rd);
      check("hold_z", io.out_z, prev.z);
      check("hold_err", io.out_err, prev.err);
    end
    if (ov && q.size() == 0)
      check("spurious_v", ov, 0);
    if (ov && io.out_ready && !flush && q.size() > 0) begin
      e = q.pop_front();
      check("ret_data", io.out_data, e.d);
      check("ret_rd", io.out_rd, e.rd);
      check("ret_z", io.out_z, e.z);
      check("ret_err", io.out_err, e.err);
    end
    last_acc = io.in_valid && exp_rdy;
    if (last_acc)
      q.push_back(mk(io.in_data, io.in_amt,
        io.in_op, io.in_rd));
    if (flush) q.delete();
    prev_hold = ov && !io.out_ready && !flush;
    prev.d   = io.out_data;
    prev.rd  = io.out_rd;
    prev.z   = io.out_z;
    prev.err = io.out_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    io.in_valid = 1'b0;
  endtask

  task automatic drain(string tag);
    int k;
    idle();
    io.out_ready = 1'b1;
    flush = 1'b0;
    k = 0;
    while (q.size() > 0 && k < 8) begin
      tick();
      k++;
    end
    tick();
    check(tag, q.size(), 0);
  endtask

  initial begin
    logic pend;
    drive(0, 0, 0, 0, 0);
    io.out_ready = 1'b0;
    #1;
    check("rst_ov", io.out_valid, 0);
    check("rst_ir", io.in_ready, 1);
    check("rst_d", io.out_data, 0);
    check("rst_sh", {sh_in, sh_val, sh_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // SLL 1<<15, 2-cycle latency
    io.out_ready = 1'b1;
    drive(1, 16'h0001, 4'd15, 3'b100, 4'd3);
    tick();
    check("sll_lat1", io.out_valid, 0);
    idle();
    tick();
    check("sll_v", io.out_valid, 1);
    check("sll_d", io.out_data, 16'h8000);
    check("sll_rd", io.out_rd, 3);
    check("sll_ze", {io.out_z, io.out_err}, 0);
    tick();

    // SRA then ROR back-to-back
    drive(1, 16'h8000, 4'd4, 3'b101, 4'd1);
    tick();
    drive(1, 16'h1234, 4'd4, 3'b110, 4'd2);
    tick();
    check("sra_d", io.out_data, 16'hF800);
    idle();
    tick();
    check("ror_v", io.out_valid, 1);
    check("ror_d", io.out_data, 16'h4123);
    tick();

    // Zero result and illegal passthrough
    drive(1, 16'h8000, 4'd1, 3'b100, 4'd4);
    tick();
    drive(1, 16'h00A5, 4'd3, 3'b011, 4'd5);
    tick();
    check("zero_d", io.out_data, 0);
    check("zero_z", io.out_z, 1);
    idle();
    tick();
    check("ill_d", io.out_data, 16'h00A5);
    check("ill_err", io.out_err, 1);
    check("ill_z", io.out_z, 0);
    tick();

    // Backpressure: third op stalls
    io.out_ready = 1'b0;
    drive(1, 16'h0F0F, 4'd0, 3'b101, 4'd6);
    tick();
    drive(1, 16'hFFFF, 4'd15, 3'b100, 4'd7);
    tick();
    drive(1, 16'h8001, 4'd15, 3'b110, 4'd8);
    #1;
    check("bp_full", io.in_ready, 0);
    tick();
    tick();
    check("bp_d", io.out_data, 16'h0F0F);
    io.out_ready = 1'b1;
    tick();
    drain("bp_drain");

    // Flush with both stages full
    io.out_ready = 1'b0;
    drive(1, 16'h1111, 4'd1, 3'b100, 4'd9);
    tick();
    drive(1, 16'h2222, 4'd2, 3'b100, 4'd10);
    tick();
    drive(1, 16'h3333, 4'd3, 3'b100, 4'd11);
    flush = 1'b1;
    io.out_ready = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    #1;
    check("flush_ov", io.out_valid, 0);
    drive(1, 16'hC000, 4'd14, 3'b101, 4'd12);
    tick();
    idle();
    tick();
    check("fl_new_d", io.out_data, 16'hFFFF);
    drain("fl_drain");

    // Random traffic with held payloads
    pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && ($urandom % 4) != 0) begin
        drive(1, 16'($urandom),
          4'($urandom), 3'($urandom_range(3, 7)),
          4'($urandom));
        pend = 1'b1;
      end
      io.out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 32) == 0;
      tick();
      if (last_acc) begin
        pend = 1'b0;
        idle();
      end
    end
    drain("rnd_drain");

    // Async reset mid-stream
    io.out_ready = 1'b0;
    drive(1, 16'hABCD, 4'd5, 3'b110, 4'd13);
    tick();
    drive(1, 16'h1357, 4'd2, 3'b101, 4'd14);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_ov", io.out_valid, 0);
    check("ar_ir", io.in_ready, 1);
    check("ar_out", {io.out_data, io.out_rd,
      io.out_z, io.out_err}, 0);
    check("ar_sh", {sh_in, sh_val, sh_op}, 0);
    q.delete();
    prev_hold = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    drive(1, 16'h0003, 4'd2, 3'b100, 4'd15);
    tick();
    idle();
    tick();
    check("ar_sll_d", io.out_data, 16'h000C);
    drain("ar_drain");

    $display("Simulation finished: %0d checks, %0d errors",
      n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
